// File: rtl/data_mem_lsu_pkg.sv
// Shared types and helpers for the data_mem_lsu load/store unit.
// LSU_ALIGN_CHECK_EN enables the misalignment check used by the top module.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    DONE
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved encoding 2'b11 is treated as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = addr_lo[0];
      SZ_WORD: m = (addr_lo != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_lsu_rdata_assembler.sv
// Gathers little-endian load bytes and publishes the extended result
// only when the final byte arrives, so resp_rdata never shows partial data.
module lsu_rdata_assembler
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cap_en_i,
  input  logic [1:0]  idx_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o
);

  logic [23:0] acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merged;
  logic [2:0]  nbytes;
  logic        last;

  always_comb begin
    nbytes  = size_to_bytes(size_i);
    last    = ({1'b0, idx_i} == (nbytes - 3'd1));
    merged  = {8'h00, acc_q};
    acc_d   = acc_q;
    rdata_d = rdata_q;
    case (idx_i)
      2'd0:    merged[7:0]   = byte_i;
      2'd1:    merged[15:8]  = byte_i;
      2'd2:    merged[23:16] = byte_i;
      default: merged[31:24] = byte_i;
    endcase
    if (cap_en_i) begin
      acc_d = merged[23:0];
      if (last) begin
        case (nbytes)
          3'd1:    rdata_d = {{24{signed_i & merged[7]}}, merged[7:0]};
          3'd2:    rdata_d = {{16{signed_i & merged[15]}}, merged[15:0]};
          default: rdata_d = merged;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-serial load/store unit in front of data_mem (one registered-read byte port).
// Optional: define LSU_ALIGN_CHECK_EN to reject misaligned requests with resp_err.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [7:0]        mem_data,
  output logic              mem_byteena,
  input  logic [7:0]        mem_q
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              cap_en_q;
  logic [1:0]        cap_idx_q;

  logic              accept;
  logic              misalign;
  logic              last_byte;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] byte_addr;

  assign accept    = req_valid && (state_q == IDLE);
  assign nbytes    = size_to_bytes(size_q);
  assign last_byte = ({1'b0, cnt_q} == (nbytes - 3'd1));
  // Natural ADDR_W-bit overflow gives the required wrap to address 0.
  assign byte_addr = addr_q + ADDR_W'(cnt_q);

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = is_misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign resp_err = (state_q == DONE) && err_q;
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = misalign ? DONE : ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (last_byte) begin
          state_d = we_q ? DONE : DRAIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // mem_q lags the read strobe by one cycle, so the lane index is delayed to match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      cap_en_q  <= (state_q == ACCESS) && !we_q;
      cap_idx_q <= cnt_q;
    end
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    resp_valid    = (state_q == DONE);
    mem_rden      = 1'b0;
    mem_wren      = 1'b0;
    mem_byteena   = 1'b0;
    mem_rdaddress = '0;
    mem_wraddress = '0;
    mem_data      = '0;
    if (state_q == ACCESS) begin
      if (we_q) begin
        mem_wren      = 1'b1;
        mem_byteena   = 1'b1;
        mem_wraddress = byte_addr;
        mem_data      = wdata_q[{cnt_q, 3'b000} +: 8];
      end else begin
        mem_rden      = 1'b1;
        mem_rdaddress = byte_addr;
      end
    end
  end

  lsu_rdata_assembler u_rdata_assembler (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .cap_en_i (cap_en_q),
    .idx_i    (cap_idx_q),
    .byte_i   (mem_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (resp_rdata)
  );

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a behavioural byte-wide data_mem.
module tb_data_mem_lsu;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rden;
  logic        mem_wren;
  logic [18:0] mem_rdaddress;
  logic [18:0] mem_wraddress;
  logic [7:0]  mem_data;
  logic        mem_byteena;
  logic [7:0]  mem_q;

  logic [7:0]  mem [0:(1<<19)-1];

  int          n_cmp = 0;
  int          n_err = 0;

  int          rcyc, nresp, nwr, nrd, nbebad;
  logic        rerr;
  logic [31:0] rdat;
  logic [18:0] wa [4];
  logic [7:0]  wb [4];
  logic [18:0] ra [4];

  int          first_rdy, acc2, r1c, r2c;
  logic [31:0] r1d, r2d;

  data_mem_lsu #(.ADDR_W(19)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_rden      (mem_rden),
    .mem_wren      (mem_wren),
    .mem_rdaddress (mem_rdaddress),
    .mem_wraddress (mem_wraddress),
    .mem_data      (mem_data),
    .mem_byteena   (mem_byteena),
    .mem_q         (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren && mem_byteena) mem[mem_wraddress] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_rdaddress];
  end

  initial begin
    #100000;
    n_err++;
    $error("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request (caller sits #1 after an edge) and watches 9 cycles.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [18:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    rcyc = -1; nresp = 0; nwr = 0; nrd = 0; nbebad = 0; rerr = 1'b0; rdat = '0;
    for (int c = 1; c <= 9; c++) begin
      if (mem_byteena !== mem_wren) nbebad++;
      if (mem_wren) begin
        if (nwr < 4) begin wa[nwr] = mem_wraddress; wb[nwr] = mem_data; end
        nwr++;
      end
      if (mem_rden) begin
        if (nrd < 4) ra[nrd] = mem_rdaddress;
        nrd++;
      end
      if (resp_valid) begin
        nresp++;
        if (rcyc < 0) begin rcyc = c; rerr = resp_err; rdat = resp_rdata; end
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", resp_err, 1'b0);
    check("rst_strobes", {mem_rden, mem_wren, mem_byteena}, 3'b000);
    check("rst_addrs", {mem_rdaddress, mem_wraddress, mem_data}, 46'h0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_req(1'b1, 2'b10, 1'b0, 19'h00010, 32'hDEADBEEF);
    check("wst_cycle", rcyc, 5);
    check("wst_nresp", nresp, 1);
    check("wst_nwr", nwr, 4);
    check("wst_nrd", nrd, 0);
    check("wst_byteena", nbebad, 0);
    check("wst_addr0", wa[0], 19'h00010);
    check("wst_addr3", wa[3], 19'h00013);
    check("wst_bytes", {wb[3], wb[2], wb[1], wb[0]}, 32'hDEADBEEF);
    check("wst_mem", {mem[19'h13], mem[19'h12], mem[19'h11], mem[19'h10]}, 32'hDEADBEEF);
    check("wst_rdata_kept", rdat, 32'h0);
    check("wst_err", rerr, 1'b0);

    run_req(1'b0, 2'b10, 1'b0, 19'h00010, 32'h0);
    check("wld_cycle", rcyc, 6);
    check("wld_nresp", nresp, 1);
    check("wld_nrd", nrd, 4);
    check("wld_nwr", nwr, 0);
    check("wld_raddr1", ra[1], 19'h00011);
    check("wld_data", rdat, 32'hDEADBEEF);
    check("wld_held", resp_rdata, 32'hDEADBEEF);

    run_req(1'b1, 2'b00, 1'b0, 19'h00001, 32'h12345680);
    check("bst_cycle", rcyc, 2);
    check("bst_nwr", nwr, 1);
    check("bst_mem", mem[19'h00001], 8'h80);
    check("bst_rdata_kept", rdat, 32'hDEADBEEF);

    run_req(1'b0, 2'b00, 1'b1, 19'h00001, 32'h0);
    check("bld_s_cycle", rcyc, 3);
    check("bld_s_data", rdat, 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b0, 19'h00001, 32'h0);
    check("bld_u_data", rdat, 32'h00000080);

    run_req(1'b0, 2'b01, 1'b1, 19'h00012, 32'h0);
    check("hld_s_cycle", rcyc, 4);
    check("hld_s_data", rdat, 32'hFFFFDEAD);

`ifdef LSU_ALIGN_CHECK_EN
    run_req(1'b0, 2'b10, 1'b0, 19'h00002, 32'h0);
    check("mis_wld_cycle", rcyc, 1);
    check("mis_wld_err", rerr, 1'b1);
    check("mis_wld_nrd", nrd, 0);
    check("mis_wld_rdata", rdat, 32'hFFFFDEAD);
    run_req(1'b1, 2'b01, 1'b0, 19'h7FFFF, 32'h00001234);
    check("mis_hst_err", rerr, 1'b1);
    check("mis_hst_nwr", nwr, 0);
    run_req(1'b0, 2'b11, 1'b0, 19'h00000, 32'h0);
    check("mis_rsv_err", rerr, 1'b1);
    check("mis_rsv_nrd", nrd, 0);
`else
    run_req(1'b1, 2'b01, 1'b0, 19'h7FFFF, 32'h00001234);
    check("wrap_hst_cycle", rcyc, 3);
    check("wrap_hst_addr0", wa[0], 19'h7FFFF);
    check("wrap_hst_addr1", wa[1], 19'h00000);
    check("wrap_hst_bytes", {wb[1], wb[0]}, 16'h1234);
    check("wrap_hst_mem", {mem[19'h00000], mem[19'h7FFFF]}, 16'h1234);
    check("wrap_hst_err", rerr, 1'b0);
    run_req(1'b0, 2'b01, 1'b0, 19'h7FFFF, 32'h0);
    check("wrap_hld_raddr1", ra[1], 19'h00000);
    check("wrap_hld_data", rdat, 32'h00001234);
    run_req(1'b1, 2'b11, 1'b0, 19'h00020, 32'hCAFEF00D);
    check("rsv_st_nwr", nwr, 4);
    run_req(1'b0, 2'b10, 1'b0, 19'h00020, 32'h0);
    check("rsv_ld_data", rdat, 32'hCAFEF00D);
`endif

    run_req(1'b1, 2'b10, 1'b0, 19'h00100, 32'h11111111);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 19'h00100; req_wdata = 32'hA1B2C3D4;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", {mem_rden, mem_wren, mem_byteena}, 3'b000);
    check("mid_rst_addrs", {mem_rdaddress, mem_wraddress, mem_data}, 46'h0);
    check("mid_rst_valid", resp_valid, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) nresp++;
      @(posedge clock); #1;
    end
    check("mid_rst_noresp", nresp, 0);
    check("mid_rst_ready", req_ready, 1'b1);
    check("mid_rst_mem", {mem[19'h103], mem[19'h102], mem[19'h101], mem[19'h100]}, 32'h111111D4);

    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 19'h00010;
    @(posedge clock); #1;
    req_size = 2'b00; req_addr = 19'h00013;
    first_rdy = -1; acc2 = 0; r1c = -1; r2c = -1; r1d = '0; r2d = '0; nresp = 0;
    for (int c = 1; c <= 16; c++) begin
      if (resp_valid) begin
        nresp++;
        if (r1c < 0) begin r1c = c; r1d = resp_rdata; end
        else begin r2c = c; r2d = resp_rdata; end
      end
      if (req_valid && req_ready) begin
        acc2++;
        if (first_rdy < 0) first_rdy = c;
      end
      @(posedge clock); #1;
      if (acc2 != 0) req_valid = 1'b0;
    end
    check("b2b_first_ready", first_rdy, 7);
    check("b2b_accepts", acc2, 1);
    check("b2b_nresp", nresp, 2);
    check("b2b_r1_cycle", r1c, 6);
    check("b2b_r1_data", r1d, 32'hDEADBEEF);
    check("b2b_r2_cycle", r2c, 10);
    check("b2b_r2_data", r2d, 32'h000000DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
